// File: rtl/soft_start_sequencer.sv
// Soft-start sequencer for a PWM power stage.
// Slews V_target from 0 up to V_setpoint one step per ramp tick, then tracks
// setpoint changes at the same slew rate. A run of overvoltage samples on
// V_feedback latches a fault that only an explicit clear, given while the run
// request is low, can release.
module soft_start_sequencer #(
    parameter int unsigned RAMP_DIV  = 50000,
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned OV_LIMIT  = 3900,
    parameter int unsigned OV_COUNT  = 16
) (
    input  logic        clock_50Min,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [11:0] V_setpoint,
    input  logic [11:0] V_feedback,
    input  logic        fault_clear,
    output logic [11:0] V_target,
    output logic        pwm_enable,
    output logic        pid_reset_n,
    output logic [1:0]  state,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_REGULATE = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [12:0] STEP_13   = 13'(RAMP_STEP);
    localparam logic [11:0] STEP_12   = 12'(RAMP_STEP);
    localparam logic [11:0] OV_LIM_12 = 12'(OV_LIMIT);
    localparam logic [7:0]  OV_CNT_8  = 8'(OV_COUNT);

    state_t      state_q, state_d;
    logic [11:0] v_target_q, v_target_d;
    logic        pwm_enable_q, pwm_enable_d;
    logic        pid_reset_n_q, pid_reset_n_d;
    logic        fault_q, fault_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  ov_cnt_q, ov_cnt_d;

    logic        active_q;
    logic        active_d;
    logic        tick;
    logic        over_v;
    logic        ov_trip;
    logic [12:0] sum_13;
    logic [12:0] diff_13;
    logic [11:0] step_up;
    logic [11:0] step_down;

    // Slew arithmetic and trip detection derived from the current registers.
    always_comb begin
        active_q = (state_q == ST_RAMP) || (state_q == ST_REGULATE);
        tick     = active_q && (tick_cnt_q == DIV_LAST);
        over_v   = V_feedback > OV_LIM_12;
        ov_trip  = active_q && (ov_cnt_q == OV_CNT_8);
        // 13-bit sum so a step past 4095 clamps to the setpoint instead of wrapping.
        sum_13   = {1'b0, v_target_q} + STEP_13;
        step_up  = (sum_13 > {1'b0, V_setpoint}) ? V_setpoint : sum_13[11:0];
        // Only meaningful when V_target is above the setpoint; a gap no larger
        // than one step lands exactly on the setpoint, so no underflow is possible.
        diff_13  = {1'b0, v_target_q} - {1'b0, V_setpoint};
        step_down = (diff_13 <= STEP_13) ? V_setpoint : (v_target_q - STEP_12);
    end

    // Next-state and next-target decision; fault trip outranks enable drop,
    // which outranks the ramp/regulate slewing.
    always_comb begin
        state_d    = state_q;
        v_target_d = v_target_q;
        case (state_q)
            ST_IDLE: begin
                v_target_d = 12'd0;
                if (enable) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (ov_trip) begin
                    state_d    = ST_FAULT;
                    v_target_d = 12'd0;
                end else if (!enable) begin
                    state_d    = ST_IDLE;
                    v_target_d = 12'd0;
                end else if (v_target_q == V_setpoint) begin
                    state_d = ST_REGULATE;
                end else if (V_setpoint < v_target_q) begin
                    v_target_d = V_setpoint;
                end else if (tick) begin
                    v_target_d = step_up;
                end
            end
            ST_REGULATE: begin
                if (ov_trip) begin
                    state_d    = ST_FAULT;
                    v_target_d = 12'd0;
                end else if (!enable) begin
                    state_d    = ST_IDLE;
                    v_target_d = 12'd0;
                end else if (tick) begin
                    if (V_setpoint > v_target_q) begin
                        v_target_d = step_up;
                    end else if (V_setpoint < v_target_q) begin
                        v_target_d = step_down;
                    end
                end
            end
            default: begin
                v_target_d = 12'd0;
                if (fault_clear && !enable) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Output, tick-counter and overvoltage-counter next values follow the chosen next state.
    always_comb begin
        active_d      = (state_d == ST_RAMP) || (state_d == ST_REGULATE);
        pwm_enable_d  = active_d;
        pid_reset_n_d = active_d;
        fault_d       = (state_d == ST_FAULT);

        // The divider runs continuously through RAMP and REGULATE and restarts
        // from zero on every fresh entry into RAMP.
        tick_cnt_d = 16'd0;
        if (active_q && active_d) begin
            tick_cnt_d = (tick_cnt_q == DIV_LAST) ? 16'd0 : (tick_cnt_q + 16'd1);
        end

        ov_cnt_d = 8'd0;
        if (active_q && over_v) begin
            ov_cnt_d = (ov_cnt_q == OV_CNT_8) ? OV_CNT_8 : (ov_cnt_q + 8'd1);
        end
    end

    // Single register bank for the FSM and every output; reset is asynchronous.
    always_ff @(posedge clock_50Min or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            v_target_q    <= 12'd0;
            pwm_enable_q  <= 1'b0;
            pid_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
            tick_cnt_q    <= 16'd0;
            ov_cnt_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            v_target_q    <= v_target_d;
            pwm_enable_q  <= pwm_enable_d;
            pid_reset_n_q <= pid_reset_n_d;
            fault_q       <= fault_d;
            tick_cnt_q    <= tick_cnt_d;
            ov_cnt_q      <= ov_cnt_d;
        end
    end

    assign V_target    = v_target_q;
    assign pwm_enable  = pwm_enable_q;
    assign pid_reset_n = pid_reset_n_q;
    assign state       = state_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_soft_start_sequencer.sv
// Bench for soft_start_sequencer: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the sequencing rules.
module tb_soft_start_sequencer;

    localparam int DIV  = 4;
    localparam int STEP = 4;
    localparam int LIM  = 3900;
    localparam int OVC  = 3;

    logic        clk;
    logic        rst_n;
    logic        en, clr;
    logic [11:0] sp, fb;
    logic [11:0] vt;
    logic        pwm, pid, flt;
    logic [1:0]  st;

    logic        en2, clr2;
    logic [11:0] sp2, fb2;
    logic [11:0] vt2;
    logic        pwm2, pid2, flt2;
    logic [1:0]  st2;

    int total = 0;
    int bad   = 0;

    soft_start_sequencer #(
        .RAMP_DIV(DIV), .RAMP_STEP(STEP), .OV_LIMIT(LIM), .OV_COUNT(OVC)
    ) dut (
        .clock_50Min(clk), .reset_n(rst_n), .enable(en), .V_setpoint(sp),
        .V_feedback(fb), .fault_clear(clr), .V_target(vt), .pwm_enable(pwm),
        .pid_reset_n(pid), .state(st), .fault(flt)
    );

    // Second instance with the largest step, used for the no-wrap saturation check.
    soft_start_sequencer #(
        .RAMP_DIV(DIV), .RAMP_STEP(255), .OV_LIMIT(LIM), .OV_COUNT(OVC)
    ) dut_big (
        .clock_50Min(clk), .reset_n(rst_n), .enable(en2), .V_setpoint(sp2),
        .V_feedback(fb2), .fault_clear(clr2), .V_target(vt2), .pwm_enable(pwm2),
        .pid_reset_n(pid2), .state(st2), .fault(flt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; sp = 12'd0; fb = 12'd0;
        en2 = 1'b0; clr2 = 1'b0; sp2 = 12'd0; fb2 = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
        total++; if (vt !== 12'd0) begin bad++; $display("FAIL reset_vt got=%0d want=0", vt); end
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%0b want=0", pwm); end
        total++; if (pid !== 1'b0) begin bad++; $display("FAIL reset_pid got=%0b want=0", pid); end
        total++; if (flt !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", flt); end
        total++; if (st2 !== 2'd0) begin bad++; $display("FAIL reset_state2 got=%0d want=0", st2); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (st !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", st); end
        $display("test_reset: state=%0d vt=%0d", st, vt);
    endtask

    task automatic test_ramp();
        int exp_v[3];
        int prev;
        exp_v = '{4, 8, 10};
        @(negedge clk); sp = 12'd10; en = 1'b1;
        @(posedge clk); #1;
        total++; if (st !== 2'd1) begin bad++; $display("FAIL ramp_entry_state got=%0d want=1", st); end
        total++; if (vt !== 12'd0) begin bad++; $display("FAIL ramp_entry_vt got=%0d want=0", vt); end
        total++; if (pwm !== 1'b1 || pid !== 1'b1) begin bad++; $display("FAIL ramp_entry_gates got=%0b%0b want=11", pwm, pid); end
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk);
            #1;
            total++; if (vt !== 12'(prev)) begin bad++; $display("FAIL ramp_hold_%0d got=%0d want=%0d", k, vt, prev); end
            @(posedge clk); #1;
            total++; if (vt !== 12'(exp_v[k])) begin bad++; $display("FAIL ramp_step_%0d got=%0d want=%0d", k, vt, exp_v[k]); end
            $display("test_ramp: step %0d vt=%0d", k, vt);
            prev = exp_v[k];
        end
        total++; if (st !== 2'd1) begin bad++; $display("FAIL ramp_before_reg got=%0d want=1", st); end
        @(posedge clk); #1;
        total++; if (st !== 2'd2) begin bad++; $display("FAIL ramp_to_regulate got=%0d want=2", st); end
    endtask

    task automatic test_regulate_down();
        int exp_v[3];
        int prev;
        int n;
        exp_v = '{6, 2, 1};
        prev = 10;
        @(negedge clk); sp = 12'd1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (vt === 12'(prev) && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
            total++; if (vt !== 12'(exp_v[k])) begin bad++; $display("FAIL reg_down_%0d got=%0d want=%0d", k, vt, exp_v[k]); end
            if (k > 0) begin
                total++; if (n !== 4) begin bad++; $display("FAIL reg_down_interval_%0d got=%0d want=4", k, n); end
            end
            $display("test_regulate_down: vt=%0d after %0d cycles", vt, n);
            prev = exp_v[k];
        end
        repeat (12) @(posedge clk);
        #1;
        total++; if (vt !== 12'd1) begin bad++; $display("FAIL reg_no_underflow got=%0d want=1", vt); end
        total++; if (st !== 2'd2) begin bad++; $display("FAIL reg_stays got=%0d want=2", st); end
    endtask

    task automatic test_overvoltage();
        @(negedge clk); fb = 12'd3901;
        repeat (2) @(posedge clk);
        @(negedge clk); fb = 12'd3900;
        repeat (6) @(posedge clk);
        #1;
        total++; if (st !== 2'd2 || flt !== 1'b0) begin bad++; $display("FAIL ov_short_run got=%0d/%0b want=2/0", st, flt); end
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL ov_at_limit_pwm got=%0b want=1", pwm); end
        @(negedge clk); fb = 12'd3901;
        repeat (3) @(posedge clk);
        #1;
        total++; if (st !== 2'd2) begin bad++; $display("FAIL ov_not_yet got=%0d want=2", st); end
        @(negedge clk); fb = 12'd0;
        @(posedge clk); #1;
        total++; if (st !== 2'd3) begin bad++; $display("FAIL ov_trip_state got=%0d want=3", st); end
        total++; if (pwm !== 1'b0 || pid !== 1'b0) begin bad++; $display("FAIL ov_trip_gates got=%0b%0b want=00", pwm, pid); end
        total++; if (vt !== 12'd0) begin bad++; $display("FAIL ov_trip_vt got=%0d want=0", vt); end
        total++; if (flt !== 1'b1) begin bad++; $display("FAIL ov_trip_fault got=%0b want=1", flt); end
        $display("test_overvoltage: state=%0d fault=%0b", st, flt);
    endtask

    task automatic test_fault_clear();
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;
        total++; if (st !== 2'd3 || flt !== 1'b1) begin bad++; $display("FAIL clr_with_enable got=%0d/%0b want=3/1", st, flt); end
        @(negedge clk); en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (st !== 2'd3) begin bad++; $display("FAIL enable_drop_alone got=%0d want=3", st); end
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        total++; if (st !== 2'd0 || flt !== 1'b0) begin bad++; $display("FAIL clr_to_idle got=%0d/%0b want=0/0", st, flt); end
        @(negedge clk); clr = 1'b0;
        $display("test_fault_clear: state=%0d fault=%0b", st, flt);
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk); sp = 12'd100; en = 1'b1;
        n = 0;
        while (vt !== 12'd8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (vt !== 12'd8) begin bad++; $display("FAIL areset_reach8 got=%0d want=8", vt); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (st !== 2'd0 || vt !== 12'd0) begin bad++; $display("FAIL areset_mid_ramp got=%0d/%0d want=0/0", st, vt); end
        total++; if (pwm !== 1'b0 || pid !== 1'b0 || flt !== 1'b0) begin bad++; $display("FAIL areset_outputs got=%0b%0b%0b want=000", pwm, pid, flt); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (st !== 2'd1 || vt !== 12'd0) begin bad++; $display("FAIL areset_restart got=%0d/%0d want=1/0", st, vt); end
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        total++; if (vt !== 12'd4) begin bad++; $display("FAIL areset_first_step got=%0d want=4", vt); end
        $display("test_async_reset: restarted ramp vt=%0d", vt);
        @(negedge clk); fb = 12'd4000;
        n = 0;
        while (st !== 2'd3 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (st !== 2'd3) begin bad++; $display("FAIL areset_reach_fault got=%0d want=3", st); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (st !== 2'd0 || flt !== 1'b0 || vt !== 12'd0) begin bad++; $display("FAIL areset_in_fault got=%0d/%0b/%0d want=0/0/0", st, flt, vt); end
        @(negedge clk); fb = 12'd0; en = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_async_reset: fault cleared by reset state=%0d", st);
    endtask

    task automatic test_saturation();
        int prev;
        int n;
        prev = 0;
        n = 0;
        @(negedge clk); sp2 = 12'd4095; en2 = 1'b1;
        while (st2 !== 2'd2 && n < 200) begin
            @(posedge clk); #1;
            n++;
            total++; if (int'(vt2) < prev) begin bad++; $display("FAIL sat_monotonic got=%0d prev=%0d", vt2, prev); end
            prev = int'(vt2);
        end
        total++; if (st2 !== 2'd2) begin bad++; $display("FAIL sat_reach_regulate got=%0d want=2", st2); end
        total++; if (vt2 !== 12'd4095) begin bad++; $display("FAIL sat_value got=%0d want=4095", vt2); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (vt2 !== 12'd4095) begin bad++; $display("FAIL sat_hold got=%0d want=4095", vt2); end
        @(negedge clk); en2 = 1'b0;
        $display("test_saturation: vt=%0d after %0d cycles", vt2, n);
    endtask

    task automatic test_random();
        int m_mode, m_vt, m_since, m_ov, n_mode, n_vt;
        int burst;
        bit act, tick, trip;
        int spi;
        int shown;
        @(negedge clk); en = 1'b0; clr = 1'b0; fb = 12'd0; sp = 12'd20; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_mode = 0; m_vt = 0; m_since = 0; m_ov = 0;
        burst = 0;
        shown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) en = ~en;
            else if (cyc == 0) en = 1'b1;
            clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) < 2) sp = 12'($urandom_range(0, 60));
            if (burst == 0 && $urandom_range(0, 99) < 4) burst = $urandom_range(1, 5);
            if (burst > 0) begin
                fb = 12'($urandom_range(3901, 4095));
                burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                fb = 12'd3900;
            end else begin
                fb = 12'($urandom_range(0, 3900));
            end

            spi  = int'(sp);
            act  = (m_mode == 1) || (m_mode == 2);
            tick = act && ((m_since % DIV) == DIV - 1);
            trip = act && (m_ov >= OVC);
            n_mode = m_mode;
            n_vt   = m_vt;
            if (m_mode == 0) begin
                n_vt = 0;
                if (en) n_mode = 1;
            end else if (m_mode == 3) begin
                n_vt = 0;
                if (clr && !en) n_mode = 0;
            end else if (trip) begin
                n_mode = 3; n_vt = 0;
            end else if (!en) begin
                n_mode = 0; n_vt = 0;
            end else if (m_mode == 1) begin
                if (m_vt == spi) n_mode = 2;
                else if (spi < m_vt) n_vt = spi;
                else if (tick) n_vt = (m_vt + STEP > spi) ? spi : m_vt + STEP;
            end else if (tick) begin
                if (spi > m_vt) n_vt = (m_vt + STEP > spi) ? spi : m_vt + STEP;
                else if (spi < m_vt) n_vt = (m_vt - STEP < spi) ? spi : m_vt - STEP;
            end
            if (act && int'(fb) > LIM) m_ov = (m_ov + 1 > OVC) ? OVC : m_ov + 1;
            else m_ov = 0;
            m_since = (act && (n_mode == 1 || n_mode == 2)) ? m_since + 1 : 0;
            m_mode = n_mode;
            m_vt   = n_vt;

            @(posedge clk); #1;
            total++;
            if (st !== 2'(m_mode)) begin
                bad++;
                if (shown < 20) $display("FAIL rand_state cyc=%0d got=%0d want=%0d", cyc, st, m_mode);
                shown++;
            end
            total++;
            if (vt !== 12'(m_vt)) begin
                bad++;
                if (shown < 20) $display("FAIL rand_vt cyc=%0d got=%0d want=%0d", cyc, vt, m_vt);
                shown++;
            end
            total++;
            if (pwm !== (m_mode == 1 || m_mode == 2) || pid !== (m_mode == 1 || m_mode == 2) || flt !== (m_mode == 3)) begin
                bad++;
                if (shown < 20) $display("FAIL rand_flags cyc=%0d got=%0b%0b%0b mode=%0d", cyc, pwm, pid, flt, m_mode);
                shown++;
            end
        end
        $display("test_random: 3000 cycles, final state=%0d vt=%0d", st, vt);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_regulate_down();
        test_overvoltage();
        test_fault_clear();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
